// File: rtl/blink_monitor_if.sv
// Signal bundle between a blink line source/observer and blink_monitor.
// master drives the blink line and clear pulse; slave is the monitor itself.
interface blink_monitor_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   blinker;
  logic                   clear_error;
  logic                   level;
  logic                   locked;
  logic                   error;
  logic [COUNT_WIDTH-1:0] last_run;
  logic [COUNT_WIDTH-1:0] edge_count;

  modport master (
    output blinker, clear_error,
    input  level, locked, error, last_run, edge_count
  );

  modport slave (
    input  blinker, clear_error,
    output level, locked, error, last_run, edge_count
  );
endinterface

// File: rtl/blink_monitor.sv
// Checks a free-running blink line: measures every high/low run against HALF_PERIOD+-TOLERANCE,
// acquires lock after LOCK_COUNT good runs, latches a sticky fault on a bad run or stall while locked.
module blink_monitor #(
  parameter int HALF_PERIOD = 10,
  parameter int TOLERANCE   = 1,
  parameter int LOCK_COUNT  = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic           clock,
  input  logic           reset,
  blink_monitor_if.slave mon
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [1:0] ST_FAULT  = 2'd3;

  localparam int GOOD_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

  localparam logic [COUNT_WIDTH-1:0] RUN_MIN =
    COUNT_WIDTH'((HALF_PERIOD > TOLERANCE) ? (HALF_PERIOD - TOLERANCE) : 0);
  localparam logic [COUNT_WIDTH-1:0] RUN_MAX     = COUNT_WIDTH'(HALF_PERIOD + TOLERANCE);
  localparam logic [COUNT_WIDTH-1:0] RUN_TIMEOUT = COUNT_WIDTH'(HALF_PERIOD + TOLERANCE + 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [GOOD_W:0]        GOOD_TARGET = (GOOD_W + 1)'(LOCK_COUNT);

  generate
    if (COUNT_WIDTH < 31 && (HALF_PERIOD + TOLERANCE + 1) > ((1 << COUNT_WIDTH) - 1)) begin : g_width_check
      $error("blink_monitor: HALF_PERIOD+TOLERANCE+1 does not fit in COUNT_WIDTH");
    end
  endgenerate

  logic                   s1, s2, s3;
  logic [COUNT_WIDTH-1:0] run_cnt;
  logic [GOOD_W-1:0]      good, good_nxt;
  logic [1:0]             state, state_nxt;
  logic                   locked_q, error_q;
  logic [COUNT_WIDTH-1:0] last_run_q, last_run_nxt;
  logic [COUNT_WIDTH-1:0] edge_count_q, edge_count_nxt;

  logic            edge_det;
  logic            run_good;
  logic            timeout;
  logic [GOOD_W:0] good_inc;

  assign edge_det = s2 ^ s3;
  assign run_good = (run_cnt >= RUN_MIN) && (run_cnt <= RUN_MAX);
  assign timeout  = !edge_det && (run_cnt == RUN_TIMEOUT);
  assign good_inc = {1'b0, good} + 1'b1;

  always_comb begin
    state_nxt      = state;
    good_nxt       = good;
    last_run_nxt   = last_run_q;
    edge_count_nxt = edge_count_q;
    case (state)
      ST_IDLE: begin
        // The first edge closes a run of unknown start, so its length is dropped.
        if (edge_det) begin
          state_nxt = ST_TRACK;
          good_nxt  = '0;
        end
      end
      ST_TRACK: begin
        if (edge_det) begin
          last_run_nxt = run_cnt;
          if (!run_good) begin
            good_nxt = '0;
          end else if (good_inc >= GOOD_TARGET) begin
            state_nxt = ST_LOCKED;
            good_nxt  = '0;
          end else begin
            good_nxt = good_inc[GOOD_W-1:0];
          end
        end else if (timeout) begin
          good_nxt = '0;
        end
      end
      ST_LOCKED: begin
        if (edge_det) begin
          last_run_nxt = run_cnt;
          if (!run_good) begin
            state_nxt = ST_FAULT;
          end else if (edge_count_q != CNT_MAX) begin
            edge_count_nxt = edge_count_q + 1'b1;
          end
        end else if (timeout) begin
          state_nxt = ST_FAULT;
        end
      end
      default: begin
        // Clear takes priority over a coincident edge, which is then ignored.
        if (mon.clear_error) begin
          state_nxt      = ST_IDLE;
          good_nxt       = '0;
          edge_count_nxt = '0;
        end else if (edge_det) begin
          last_run_nxt = run_cnt;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      run_cnt      <= '0;
      good         <= '0;
      state        <= ST_IDLE;
      locked_q     <= 1'b0;
      error_q      <= 1'b0;
      last_run_q   <= '0;
      edge_count_q <= '0;
    end else begin
      s1 <= mon.blinker;
      s2 <= s1;
      s3 <= s2;
      if (edge_det) begin
        run_cnt <= COUNT_WIDTH'(1);
      end else if (run_cnt != CNT_MAX) begin
        run_cnt <= run_cnt + 1'b1;
      end
      good         <= good_nxt;
      state        <= state_nxt;
      locked_q     <= (state_nxt == ST_LOCKED);
      error_q      <= (state_nxt == ST_FAULT);
      last_run_q   <= last_run_nxt;
      edge_count_q <= edge_count_nxt;
    end
  end

  assign mon.level      = s2;
  assign mon.locked     = locked_q;
  assign mon.error      = error_q;
  assign mon.last_run   = last_run_q;
  assign mon.edge_count = edge_count_q;

endmodule

// File: tb/tb_blink_monitor.sv
// Directed bench for blink_monitor: a table of run segments with expected outputs,
// followed by hand-written clear, timeout, glitch, clear-vs-edge and reset sequences.
module tb_blink_monitor;

  logic clock;
  logic reset;

  blink_monitor_if #(.COUNT_WIDTH(16)) bus ();

  blink_monitor #(
    .HALF_PERIOD(10),
    .TOLERANCE  (1),
    .LOCK_COUNT (4),
    .COUNT_WIDTH(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mon  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string name;
    bit    lvl;
    int    len;
    int    reps;
    bit    exp_level;
    bit    exp_locked;
    bit    exp_error;
    int    exp_last;
    int    exp_ec;
  } vec_t;

  vec_t vecs[11];
  int   checks = 0;
  int   passes = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Hold the blink line at lvl for n sampling edges.
  task automatic run(input bit lvl, input int n);
    bus.blinker = lvl;
    repeat (n) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else
      passes++;
  endtask

  task automatic check_out(input string name, input bit l, input bit e, input int last, input int ec);
    check({name, ".locked"}, 32'(bus.locked), 32'(l));
    check({name, ".error"}, 32'(bus.error), 32'(e));
    check({name, ".last_run"}, 32'(bus.last_run), last);
    check({name, ".edge_count"}, 32'(bus.edge_count), ec);
  endtask

  task automatic pulse_clear();
    bus.clear_error = 1'b1;
    tick();
    bus.clear_error = 1'b0;
  endtask

  initial begin
    //             name                 lvl len reps lev lck err last ec
    vecs[0]  = '{"idle_low",            1'b0, 10, 1,  1'b0, 1'b0, 1'b0, 0,  0};
    vecs[1]  = '{"first_edge_dropped",  1'b1, 10, 1,  1'b1, 1'b0, 1'b0, 0,  0};
    vecs[2]  = '{"tracking",            1'b0, 10, 3,  1'b0, 1'b0, 1'b0, 10, 0};
    vecs[3]  = '{"lock_5th_edge",       1'b1, 10, 1,  1'b1, 1'b1, 1'b0, 10, 0};
    vecs[4]  = '{"twenty_periods",      1'b0, 10, 40, 1'b1, 1'b1, 1'b0, 10, 40};
    vecs[5]  = '{"run9_a",              1'b0, 9,  1,  1'b0, 1'b1, 1'b0, 10, 41};
    vecs[6]  = '{"run11_a",             1'b1, 11, 1,  1'b1, 1'b1, 1'b0, 9,  42};
    vecs[7]  = '{"run9_b",              1'b0, 9,  1,  1'b0, 1'b1, 1'b0, 11, 43};
    vecs[8]  = '{"run11_b",             1'b1, 11, 1,  1'b1, 1'b1, 1'b0, 9,  44};
    vecs[9]  = '{"run12",               1'b0, 12, 1,  1'b0, 1'b1, 1'b0, 11, 45};
    vecs[10] = '{"run12_fault",         1'b1, 10, 1,  1'b1, 1'b0, 1'b1, 12, 45};

    bus.blinker     = 1'b0;
    bus.clear_error = 1'b0;
    reset           = 1'b1;
    repeat (2) tick();
    check_out("reset", 1'b0, 1'b0, 0, 0);
    check("reset.level", 32'(bus.level), 0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      for (int r = 0; r < vecs[i].reps; r++)
        run(vecs[i].lvl ^ r[0], vecs[i].len);
      check({vecs[i].name, ".level"}, 32'(bus.level), 32'(vecs[i].exp_level));
      check_out(vecs[i].name, vecs[i].exp_locked, vecs[i].exp_error, vecs[i].exp_last, vecs[i].exp_ec);
    end

    // Clear from FAULT with a quiet line, then exact relock timing.
    pulse_clear();
    check_out("clear", 1'b0, 1'b0, 12, 0);
    run(1'b0, 10); run(1'b1, 10); run(1'b0, 10); run(1'b1, 10);
    check("relock_4_edges.locked", 32'(bus.locked), 0);
    run(1'b0, 2);
    check("relock_edge_cycle.locked", 32'(bus.locked), 0);
    run(1'b0, 1);
    check("relock_next_cycle.locked", 32'(bus.locked), 1);
    run(1'b0, 7);
    run(1'b1, 10); run(1'b0, 10); run(1'b1, 10); run(1'b0, 10);

    // Stalled line while locked: fault lands 12 cycles after the last detected edge.
    run(1'b1, 14);
    check_out("stall_before_timeout", 1'b1, 1'b0, 10, 5);
    run(1'b1, 1);
    check_out("stall_timeout", 1'b0, 1'b1, 10, 5);
    run(1'b1, 20);
    check_out("stall_frozen", 1'b0, 1'b1, 10, 5);

    // Clear coinciding with a detected edge: edge ignored, five more edges to lock.
    run(1'b0, 2);
    pulse_clear();
    check_out("clear_on_edge", 1'b0, 1'b0, 10, 0);
    run(1'b0, 7);
    run(1'b1, 10); run(1'b0, 10); run(1'b1, 10); run(1'b0, 10);
    check("clear_on_edge_4.locked", 32'(bus.locked), 0);
    run(1'b1, 10);
    check_out("clear_on_edge_relock", 1'b1, 1'b0, 10, 0);

    // 3-cycle glitch while locked.
    run(1'b0, 3);
    run(1'b1, 10);
    check_out("glitch", 1'b0, 1'b1, 3, 1);
    pulse_clear();
    check_out("glitch_clear", 1'b0, 1'b0, 3, 0);
    run(1'b0, 10); run(1'b1, 10); run(1'b0, 10); run(1'b1, 10); run(1'b0, 10);
    check_out("glitch_relock", 1'b1, 1'b0, 10, 0);

    // Reset mid-LOCKED with the line high at release.
    run(1'b1, 5);
    check_out("pre_reset", 1'b1, 1'b0, 10, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_out("mid_reset", 1'b0, 1'b0, 0, 0);
    check("mid_reset.level", 32'(bus.level), 0);
    run(1'b1, 10); run(1'b0, 10); run(1'b1, 10); run(1'b0, 10);
    check("post_reset_4.locked", 32'(bus.locked), 0);
    run(1'b1, 2);
    check("post_reset_edge_cycle.locked", 32'(bus.locked), 0);
    run(1'b1, 1);
    check("post_reset_next_cycle.locked", 32'(bus.locked), 1);
    run(1'b1, 7);
    check_out("post_reset_relock", 1'b1, 1'b0, 10, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
